mul_seq_16bit: RTL
==================

MUL_SEQ_16BIT -- requirements
Module: mul_seq_16bit

Interface
REQ-001 Parameter: none; all widths fixed at 16-bit operands and 32-bit product.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request a multiply; honoured only in IDLE.
REQ-005 flush  input  1  pipeline flush; synchronous abort of any operation in progress.
REQ-006 A  input  16  multiplicand, unsigned, captured when start is accepted.
REQ-007 B  input  16  multiplier, unsigned, captured when start is accepted.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse, high only in DONE state.
REQ-010 Product  output  32  unsigned A*B, registered, held until next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE; encoding is an implementation choice.
REQ-012 IDLE: start=1 and flush=0 -> load mcand=A, mq=B, acc=0, count=0, go RUN; otherwise stay IDLE.
REQ-013 RUN: each cycle perform one shift-add step; at count=15 go DONE, else count+1.
REQ-014 Step: if mq[0]=1, {c,s}=acc+mcand via the shared 16-bit adder with Cin=0; else {c,s}={0,acc}; then {acc,mq} <= {c,s,mq[15:1]}.
REQ-015 Carry c SHALL be derived as (acc[15]&mcand[15]) | ((acc[15]^mcand[15]) & ~s[15]); the adder's overflow output is unused.
REQ-016 On the RUN->DONE transition, Product SHALL load {acc,mq} of the final step.
REQ-017 DONE: done=1 for exactly one cycle, then go IDLE unconditionally; start in DONE is ignored.
REQ-018 Latency: start sampled in cycle 0 -> RUN cycles 1..16 -> done=1 in cycle 17; Product valid from cycle 17.
REQ-019 start while busy SHALL be ignored, with no effect on operands, count or Product.
REQ-020 flush=1 in any state -> IDLE next cycle, no done pulse, Product unchanged; flush beats a simultaneous start.
REQ-021 A and B changing during RUN SHALL NOT affect the result.

Reset
REQ-022 rst_n=0 at a rising edge -> state IDLE, busy=0, done=0, Product=0, acc/mq/mcand/count=0.
REQ-023 Reset mid-operation SHALL abort with no done pulse; reset has priority over flush and start.

Structure
REQ-024 A shared package SHALL hold the FSM state type/constants (IDLE, RUN, DONE) and the iteration count constant (16).
REQ-025 The block SHALL instantiate exactly one adder_16bit as its sole arithmetic sub-module; no other adders or multipliers.
REQ-026 Counter SHALL be 4 bits; acc, mq and mcand 16 bits each.

Verification
REQ-027 A=0x0003, B=0x0005, start one cycle -> done in cycle 17, Product=0x0000000F, busy high cycles 1..17.
REQ-028 A=0xFFFF, B=0xFFFF -> Product=0xFFFE0001 (carry path exercised on every step).
REQ-029 A=0x1234, B=0x0000 then A=0x0000, B=0xABCD -> Product=0x00000000 both; A=0x8000, B=0x0002 -> 0x00010000.
REQ-030 Start A=0x0010, B=0x0010; in cycle 5 assert start with A=0xFFFF, B=0xFFFF -> ignored; Product=0x00000100 in cycle 17.
REQ-031 Start, then flush in cycle 8 -> IDLE in cycle 9, no done, Product keeps previous value; new start afterwards completes normally.
REQ-032 Start, rst_n=0 in cycle 10 -> all outputs 0 next cycle, no done pulse; flush and start held with rst_n=0 -> state stays IDLE.

Source files
------------

// File: rtl/mul_seq_16bit_pkg.sv
// Shared types and constants for the sequential 16x16 shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_seq_16bit_pkg;

    localparam int unsigned OP_W      = 16;
    localparam int unsigned PROD_W    = 2 * OP_W;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NUM_STEPS = 16;

    // Count value of the final shift-add step; the RUN state ends on it.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Carry out of an MSB-slice add with carry-in 0 to the adder, rebuilt
    // from the operand MSBs and the sum MSB: if the MSBs differ, the sum bit
    // is the inverse of the carry into that bit, which is also the carry out.
    function automatic logic add_carry_out(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    endfunction

endpackage

// File: rtl/mul_seq_16bit_if.sv
// Request/result bundle of the sequential multiplier.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the multiplier is busy.
//   start, flush : requester -> multiplier controls
//   A, B         : requester -> multiplier unsigned operands
//   busy, done   : multiplier status (busy in RUN/DONE, done one-cycle pulse)
//   Product      : multiplier registered 32-bit result
interface mul_seq_16bit_if;
    import mul_seq_16bit_pkg::*;

    logic              start;
    logic              flush;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] Product;

    modport master (
        output start, flush, A, B,
        input  busy, done, Product
    );

    modport slave (
        input  start, flush, A, B,
        output busy, done, Product
    );

endinterface

// File: rtl/mul_seq_16bit_adder.sv
// 16-bit ripple adder shared by the multiplier datapath.
// Latency: combinational.
// Backpressure: none.
//   a_i, b_i, cin_i : operands and carry-in
//   sum_o           : 16-bit sum
//   ovf_o           : signed overflow flag
module adder_16bit
    import mul_seq_16bit_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    input  logic            cin_i,
    output logic [OP_W-1:0] sum_o,
    output logic            ovf_o
);

    assign sum_o = a_i + b_i + {{(OP_W-1){1'b0}}, cin_i};
    assign ovf_o = (a_i[OP_W-1] == b_i[OP_W-1]) && (sum_o[OP_W-1] != a_i[OP_W-1]);

endmodule

// File: rtl/mul_seq_16bit.sv
// Sequential unsigned 16x16->32 shift-add multiplier, one step per cycle.
// Latency: start accepted in cycle 0 -> done pulse and Product valid in cycle 17.
// Backpressure: none; start while busy is dropped, flush aborts without done.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset, beats flush and start
//   bus   : slave side of mul_seq_16bit_if (start/flush/A/B in, busy/done/Product out)
module mul_seq_16bit
    import mul_seq_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mul_seq_16bit_if.slave   bus
);

    state_e             state_q,   state_d;
    logic [OP_W-1:0]    acc_q,     acc_d;
    logic [OP_W-1:0]    mq_q,      mq_d;
    logic [OP_W-1:0]    mcand_q,   mcand_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [PROD_W-1:0]  product_q, product_d;

    logic [OP_W-1:0]    add_sum;
    logic               add_ovf_unused;
    logic               add_carry;
    logic               step_c;
    logic [OP_W-1:0]    step_s;
    logic [OP_W-1:0]    step_acc;
    logic [OP_W-1:0]    step_mq;

    // The only arithmetic in the block: acc + mcand.
    adder_16bit u_adder (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .cin_i (1'b0),
        .sum_o (add_sum),
        .ovf_o (add_ovf_unused)
    );

    // One shift-add step: add mcand when the multiplier LSB is set, then shift
    // the 33-bit {carry, sum, mq} right by one into {acc, mq}.
    always_comb begin
        add_carry = add_carry_out(acc_q[OP_W-1], mcand_q[OP_W-1], add_sum[OP_W-1]);
        step_c    = mq_q[0] ? add_carry : 1'b0;
        step_s    = mq_q[0] ? add_sum   : acc_q;
        step_acc  = {step_c, step_s[OP_W-1:1]};
        step_mq   = {step_s[0], mq_q[OP_W-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    mcand_d = bus.A;
                    mq_d    = bus.B;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    // Abort: datapath is left as-is, Product untouched.
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    if (count_q == LAST_STEP) begin
                        product_d = {step_acc, step_mq};
                        state_d   = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.Product = product_q;

endmodule
